// File: rtl/des_block_sequencer.sv
// Drives an external iterative DES core over a span of 64-bit blocks held in a 32-bit input RAM,
// writing results to a 32-bit output RAM. Supports ECB/CBC, encrypt/decrypt, block count and abort.
module des_block_sequencer #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              decrypt,
  input  logic              cbc_en,
  input  logic [63:0]       iv,
  input  logic [ADDR_W-2:0] num_blocks,
  output logic [ADDR_W-1:0] ramI_addr,
  input  logic [31:0]       ramI_dout,
  output logic [ADDR_W-1:0] ramO_addr,
  output logic [31:0]       ramO_din,
  output logic              ramO_we,
  output logic [63:0]       des_in,
  output logic [3:0]        des_round_sel,
  output logic              des_decrypt,
  input  logic [63:0]       des_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] blocks_left
);

  localparam int unsigned BLK_W    = 64;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned CNT_W    = ADDR_W - 1;
  localparam int unsigned FULL_CNT = 1 << CNT_W;

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, ROUND, WR_LO, WR_HI, NEXT, DONE
  } state_t;

  state_t             state;
  state_t             nextState;
  logic               modeCbc;
  logic [BLK_W-1:0]   chain;
  logic [BLK_W-1:0]   cin;
  logic [BLK_W-1:0]   result;
  logic [WORD_W-1:0]  lo;
  logic [BLK_W-1:0]   blk;
  logic [BLK_W-1:0]   resultNext;
  logic               lastRound;
  logic               busyNext;
  logic               doneNext;
  logic               weNext;

  assign blk        = {ramI_dout, lo};
  assign lastRound  = (des_round_sel == SEL_W'(15));
  assign resultNext = (modeCbc && des_decrypt) ? (des_out ^ chain) : des_out;

  // State register
  always_ff @(posedge sys_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next state and next values of the registered status outputs
  always_comb begin
    nextState = state;
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    weNext    = 1'b0;
    case (state)
      IDLE:    if (start && !abort) nextState = RD0;
      RD0:     nextState = RD1;
      RD1:     nextState = RD2;
      RD2:     nextState = ROUND;
      ROUND:   if (lastRound) nextState = WR_LO;
      WR_LO:   nextState = WR_HI;
      WR_HI:   nextState = NEXT;
      NEXT:    nextState = (blocks_left == ADDR_W'(1)) ? DONE : RD0;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort && state != IDLE) nextState = IDLE;
    busyNext = (nextState != IDLE) && (nextState != DONE);
    doneNext = (nextState == DONE);
    weNext   = (nextState == WR_LO) || (nextState == WR_HI);
  end

  // Datapath: addresses, chaining value and DES interface
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      ramI_addr     <= '0;
      ramO_addr     <= '0;
      ramO_din      <= '0;
      ramO_we       <= 1'b0;
      des_in        <= '0;
      des_round_sel <= '0;
      des_decrypt   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      blocks_left   <= '0;
      modeCbc       <= 1'b0;
      chain         <= '0;
      cin           <= '0;
      result        <= '0;
      lo            <= '0;
    end else begin
      busy    <= busyNext;
      done    <= doneNext;
      ramO_we <= weNext;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            des_decrypt <= decrypt;
            modeCbc     <= cbc_en;
            chain       <= iv;
            blocks_left <= (num_blocks == '0) ? ADDR_W'(FULL_CNT) : ADDR_W'(num_blocks);
            ramI_addr   <= '0;
            ramO_addr   <= '0;
          end
        end
        RD0: ramI_addr <= ramI_addr + ADDR_W'(1);
        RD1: begin
          lo        <= ramI_dout;
          ramI_addr <= ramI_addr + ADDR_W'(1);
        end
        RD2: begin
          des_in        <= (modeCbc && !des_decrypt) ? (blk ^ chain) : blk;
          cin           <= blk;
          des_round_sel <= '0;
        end
        ROUND: begin
          des_round_sel <= des_round_sel + SEL_W'(1);
          if (lastRound) begin
            result   <= resultNext;
            ramO_din <= resultNext[WORD_W-1:0];
            if (modeCbc) chain <= des_decrypt ? cin : des_out;
          end
        end
        // The port shows base+1 only during WR_HI; NEXT sees the block base again.
        WR_LO: begin
          ramO_addr <= ramO_addr + ADDR_W'(1);
          ramO_din  <= result[BLK_W-1:WORD_W];
        end
        WR_HI: ramO_addr <= ramO_addr - ADDR_W'(1);
        NEXT: begin
          ramO_addr   <= ramO_addr + ADDR_W'(2);
          blocks_left <= blocks_left - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_sequencer.sv
// Self-checking bench for des_block_sequencer: RAM models, a stand-in DES core and a
// block-level ECB/CBC reference model; table-driven runs plus random runs and reset cases.
module tb_des_block_sequencer;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [63:0] KEY   = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] ADDC  = 64'h9E37_79B9_7F4A_7C15;
  localparam logic [63:0] KAT_P = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] KAT_C = 64'h85E8_1354_0F0A_B405;
  localparam int FILL_ZERO = 0, FILL_RAND = 1, FILL_KATP = 2, FILL_KATC = 3, FILL_PREV = 4;

  typedef struct {
    int          n;
    bit          dec;
    bit          cbc;
    logic [63:0] iv;
    int          fill;
    int          abortCyc;
    int          extraStart;
    bit          kat;
    logic [31:0] expW0;
    logic [31:0] expW1;
    int          expDone;
    int          expWrites;
  } vec_t;

  logic          sys_clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          decrypt;
  logic          cbc_en;
  logic [63:0]   iv;
  logic [AW-2:0] num_blocks;
  logic [AW-1:0] ramI_addr;
  logic [31:0]   ramI_dout;
  logic [AW-1:0] ramO_addr;
  logic [31:0]   ramO_din;
  logic          ramO_we;
  logic [63:0]   des_in;
  logic [3:0]    des_round_sel;
  logic          des_decrypt;
  logic [63:0]   des_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] blocks_left;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ramI [DEPTH];
  logic [31:0] ramO [DEPTH];
  int          wrEpoch [DEPTH];
  int          epoch = 0;
  int          writeTotal = 0;
  logic [63:0] junk;
  vec_t        vecs [9];

  des_block_sequencer #(.ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .abort(abort),
    .decrypt(decrypt), .cbc_en(cbc_en), .iv(iv), .num_blocks(num_blocks),
    .ramI_addr(ramI_addr), .ramI_dout(ramI_dout), .ramO_addr(ramO_addr),
    .ramO_din(ramO_din), .ramO_we(ramO_we), .des_in(des_in),
    .des_round_sel(des_round_sel), .des_decrypt(des_decrypt), .des_out(des_out),
    .busy(busy), .done(done), .blocks_left(blocks_left)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Synchronous-read input RAM, output RAM tagged with the run that wrote each word
  always @(posedge sys_clk) begin
    ramI_dout <= ramI[ramI_addr];
    junk      <= {$urandom, $urandom};
    if (ramO_we) begin
      ramO[ramO_addr]    <= ramO_din;
      wrEpoch[ramO_addr] <= epoch;
      writeTotal         <= writeTotal + 1;
    end
  end

  // Stand-in DES core: a bijective toy cipher that also reproduces the standard
  // known-answer pair; its result is only meaningful while round 15 is selected.
  function automatic logic [63:0] tf(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ KEY;
    return {y[50:0], y[63:51]} + ADDC;
  endfunction

  function automatic logic [63:0] tfInv(input logic [63:0] y);
    logic [63:0] z;
    z = y - ADDC;
    return {z[12:0], z[63:13]} ^ KEY;
  endfunction

  function automatic logic [63:0] mockEnc(input logic [63:0] x);
    if (x == KAT_P) return KAT_C;
    if (x == tfInv(KAT_C)) return tf(KAT_P);
    return tf(x);
  endfunction

  function automatic logic [63:0] mockDec(input logic [63:0] y);
    if (y == KAT_C) return KAT_P;
    if (y == tf(KAT_P)) return tfInv(KAT_C);
    return tfInv(y);
  endfunction

  assign des_out = (des_round_sel == 4'd15) ?
                   (des_decrypt ? mockDec(des_in) : mockEnc(des_in)) : junk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_addrs"}, 64'({ramI_addr, ramO_addr, blocks_left}), 64'd0);
    chk({tag, "_ctrl"}, 64'({ramO_we, busy, done, des_decrypt, des_round_sel}), 64'd0);
    chk({tag, "_des_in"}, des_in, 64'd0);
    chk({tag, "_ramO_din"}, 64'(ramO_din), 64'd0);
  endtask

  task automatic runJob(input vec_t v, input string tag);
    int          n, limit, doneCyc, doneCnt, busyErr, busyEnd, completed, wr0, ramErr;
    bit          expBusy, wrote, bad;
    logic [63:0] chainM, p, c, o;
    logic [31:0] expO [DEPTH];
    n = (v.n == 0) ? 256 : v.n;
    for (int i = 0; i < int'(DEPTH); i++) begin
      case (v.fill)
        FILL_ZERO: ramI[i] = 32'd0;
        FILL_RAND: ramI[i] = $urandom;
        FILL_PREV: ramI[i] = ramO[i];
        default:   ramI[i] = 32'd0;
      endcase
      expO[i] = 32'd0;
    end
    if (v.fill == FILL_KATP) begin ramI[0] = KAT_P[31:0]; ramI[1] = KAT_P[63:32]; end
    if (v.fill == FILL_KATC) begin ramI[0] = KAT_C[31:0]; ramI[1] = KAT_C[63:32]; end

    // Block-level reference: textbook ECB/CBC over the stand-in cipher
    chainM = v.iv;
    for (int b = 0; b < n; b++) begin
      p = {ramI[2*b+1], ramI[2*b]};
      if (!v.dec) begin
        c = mockEnc(v.cbc ? (p ^ chainM) : p);
        o = c;
        if (v.cbc) chainM = c;
      end else begin
        c = mockDec(p);
        o = v.cbc ? (c ^ chainM) : c;
        if (v.cbc) chainM = p;
      end
      expO[2*b]   = o[31:0];
      expO[2*b+1] = o[63:32];
    end

    epoch++;
    wr0 = writeTotal;
    @(negedge sys_clk);
    decrypt = v.dec; cbc_en = v.cbc; iv = v.iv; num_blocks = 8'(v.n); start = 1'b1;
    doneCyc = 0; doneCnt = 0; busyErr = 0;
    busyEnd = (v.abortCyc > 0) ? v.abortCyc : 22 * n;
    limit   = 22 * n + 6;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) begin
        decrypt = 1'($urandom); cbc_en = 1'($urandom);
        iv = {$urandom, $urandom}; num_blocks = 8'($urandom);
      end
      expBusy = (cyc <= busyEnd);
      if (busy !== expBusy) busyErr++;
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCyc == 0) doneCyc = cyc;
      end
      if (v.abortCyc > 0 && cyc == v.abortCyc + 1) begin
        chk({tag, "_abort_busy"}, 64'(busy), 64'd0);
        chk({tag, "_abort_we"}, 64'(ramO_we), 64'd0);
      end
      start = (cyc == v.extraStart);
      abort = 1'b0;
      if (cyc == v.abortCyc) begin
        chk({tag, "_abort_round_sel"}, 64'(des_round_sel), 64'd7);
        abort = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;

    chk({tag, "_done_cycle"}, 64'(doneCyc), 64'(v.expDone));
    chk({tag, "_done_count"}, 64'(doneCnt), (v.expDone != 0) ? 64'd1 : 64'd0);
    chk({tag, "_busy_errors"}, 64'(busyErr), 64'd0);
    chk({tag, "_writes"}, 64'(writeTotal - wr0), 64'(v.expWrites));

    completed = (v.abortCyc > 0) ? (v.abortCyc - 1) / 22 : n;
    ramErr = 0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      wrote = (wrEpoch[a] == epoch);
      bad   = (a < 2 * completed) ? (!wrote || ramO[a] !== expO[a]) : wrote;
      if (bad) ramErr++;
    end
    chk({tag, "_ram_errors"}, 64'(ramErr), 64'd0);
    if (v.kat) begin
      chk({tag, "_kat_w0"}, 64'(ramO[0]), 64'(v.expW0));
      chk({tag, "_kat_w1"}, 64'(ramO[1]), 64'(v.expW1));
    end
    if (v.abortCyc == 0) begin
      chk({tag, "_end_ramI_addr"}, 64'(ramI_addr), 64'(AW'(2 * n)));
      chk({tag, "_end_ramO_addr"}, 64'(ramO_addr), 64'(AW'(2 * n)));
      chk({tag, "_end_blocks_left"}, 64'(blocks_left), 64'd0);
    end
  endtask

  initial begin
    vec_t rv;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; decrypt = 1'b0;
    cbc_en = 1'b0; iv = 64'd0; num_blocks = '0;
    for (int i = 0; i < int'(DEPTH); i++) ramI[i] = 32'd0;
    repeat (3) @(negedge sys_clk);
    checkAllZero("reset");
    reset_n = 1'b1;
    @(negedge sys_clk);

    //          n  dec   cbc   iv     fill       abort extra kat  w0            w1            done  writes
    vecs[0] = '{1, 1'b0, 1'b0, 64'd0, FILL_KATP, 0,    0,    1'b1, 32'h0F0AB405, 32'h85E81354, 23,   2};
    vecs[1] = '{1, 1'b1, 1'b0, 64'd0, FILL_KATC, 0,    0,    1'b1, 32'h89ABCDEF, 32'h01234567, 23,   2};
    vecs[2] = '{3, 1'b0, 1'b1, KAT_P, FILL_ZERO, 0,    0,    1'b1, 32'h0F0AB405, 32'h85E81354, 67,   6};
    vecs[3] = '{3, 1'b1, 1'b1, KAT_P, FILL_PREV, 0,    0,    1'b1, 32'h00000000, 32'h00000000, 67,   6};
    vecs[4] = '{0, 1'b0, 1'b0, 64'd0, FILL_RAND, 0,    0,    1'b0, 32'd0,        32'd0,        5633, 512};
    vecs[5] = '{5, 1'b0, 1'b1, 64'h0F1E2D3C4B5A6978, FILL_RAND, 0, 10, 1'b0, 32'd0, 32'd0,     111,  10};
    vecs[6] = '{4, 1'b1, 1'b0, 64'd0, FILL_RAND, 33,   0,    1'b0, 32'd0,        32'd0,        0,    2};
    vecs[7] = '{2, 1'b1, 1'b1, 64'hFEDCBA9876543210, FILL_RAND, 0, 0, 1'b0, 32'd0, 32'd0,      45,   4};
    vecs[8] = '{7, 1'b1, 1'b1, 64'h0011223344556677, FILL_RAND, 0, 0, 1'b0, 32'd0, 32'd0,      155,  14};

    for (int k = 0; k < 9; k++) runJob(vecs[k], $sformatf("vec%0d", k));

    // Reset in the middle of ROUND returns every output to 0 at the next edge
    for (int i = 0; i < int'(DEPTH); i++) ramI[i] = $urandom;
    @(negedge sys_clk);
    num_blocks = 8'd2; decrypt = 1'b0; cbc_en = 1'b0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (7) @(negedge sys_clk);
    chk("midreset_round_sel", 64'(des_round_sel), 64'd4);
    reset_n = 1'b0;
    @(negedge sys_clk);
    checkAllZero("midreset");
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("midreset_idle", 64'({busy, done, ramO_we}), 64'd0);

    for (int r = 0; r < 4; r++) begin
      rv.n = int'($urandom_range(1, 12));
      rv.dec = 1'($urandom); rv.cbc = 1'($urandom); rv.iv = {$urandom, $urandom};
      rv.fill = FILL_RAND; rv.abortCyc = 0; rv.extraStart = 0; rv.kat = 1'b0;
      rv.expW0 = 32'd0; rv.expW1 = 32'd0;
      rv.expDone = 22 * rv.n + 1; rv.expWrites = 2 * rv.n;
      runJob(rv, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_block_sequencer.md
Name: des_block_sequencer

Overview:
- Controller that runs the DES core over a span of 64-bit blocks held in a 32-bit dual-port input RAM and writes the results to a 32-bit output RAM.
- Supports ECB and CBC chaining, encrypt and decrypt, a programmable block count and abort.
- Sits in the sys_clk domain between the host-facing trigger/wire endpoints and the RAM/DES datapath. It replaces the ad-hoc state machine that has so far lived in the top level.

Parameters:
- ADDR_W, 9, RAM word-address width. Block count width is ADDR_W-1.

Ports:
- sys_clk  in  1  Single clock for all logic.
- reset_n  in  1  Synchronous, active-low reset.
- start  in  1  One-cycle pulse that begins a run. Ignored while busy.
- abort  in  1  Terminates a run. Takes priority over start.
- decrypt  in  1  Mode: 0 = encrypt, 1 = decrypt. Sampled at start.
- cbc_en  in  1  Mode: 0 = ECB, 1 = CBC. Sampled at start.
- iv  in  64  CBC initial vector. Sampled at start.
- num_blocks  in  ADDR_W-1  Number of blocks to process. 0 means 2^(ADDR_W-1). Sampled at start.
- ramI_addr  out  ADDR_W  Input RAM read address. Read data arrives 1 cycle later.
- ramI_dout  in  32  Input RAM read data.
- ramO_addr  out  ADDR_W  Output RAM write address.
- ramO_din  out  32  Output RAM write data.
- ramO_we  out  1  Output RAM write enable.
- des_in  out  64  Input word to the DES core.
- des_round_sel  out  4  Round select to the DES core.
- des_decrypt  out  1  Latched copy of decrypt.
- des_out  in  64  DES core result. Valid at the clock edge where des_round_sel==15.
- busy  out  1  High while a run is in progress.
- done  out  1  One-cycle pulse at the end of a successful run.
- blocks_left  out  ADDR_W  Number of blocks still to process.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, including ramI_addr, ramO_addr, des_in, des_round_sel, busy, done, ramO_we and blocks_left.
  - Reset overrides everything, including a run in progress.
- States: IDLE, RD0, RD1, RD2, ROUND, WR_LO, WR_HI, NEXT, DONE.
- IDLE:
  - On start, latch decrypt/cbc_en/iv into des_decrypt/mode/chain.
  - blocks_left <= (num_blocks==0 ? 2^(ADDR_W-1) : num_blocks).
  - ramI_addr <= 0, ramO_addr <= 0.
  - Go to RD0.
- RD0: ramI_addr += 1. Go to RD1.
- RD1: lo <= ramI_dout. ramI_addr += 1. Go to RD2.
- RD2:
  - Form blk = {ramI_dout, lo}.
  - des_in <= (cbc_en && !decrypt) ? blk ^ chain : blk.
  - cin <= blk.
  - des_round_sel <= 0. Go to ROUND.
- ROUND:
  - des_round_sel increments by 1 each cycle.
  - At the edge where des_round_sel==15, capture the result:
    - result <= (cbc_en && decrypt) ? des_out ^ chain : des_out.
    - If CBC, update chain: chain <= decrypt ? cin : des_out.
  - Go to WR_LO. des_round_sel wraps to 0.
- WR_LO: ramO_we=1, ramO_din=result[31:0], at ramO_addr.
- WR_HI: ramO_we=1, ramO_din=result[63:32], at ramO_addr+1.
- NEXT:
  - ramO_addr += 2. blocks_left -= 1.
  - If the new blocks_left is 0, go to DONE; otherwise go to RD0.
- DONE: done=1 for exactly 1 cycle. Go to IDLE.
- ramO_we is high only in WR_LO and WR_HI.
- Word order: the low word is at the even address and is transferred first.
- Timing:
  - Each block takes 22 cycles.
  - done is high in cycle 22*N+1, counted from the edge that sampled start.
  - busy is high in cycles 1 through 22*N.
- Address wrap: ramI_addr and ramO_addr wrap modulo 2^ADDR_W. A full-RAM run therefore ends with both addresses back at 0.
- start while busy is ignored. start in the DONE cycle is also ignored.
- abort in any non-IDLE state:
  - Next state is IDLE, with busy=0 and ramO_we=0.
  - No done pulse.
  - Any writes already made remain in the output RAM.
- abort together with start in IDLE: stay in IDLE.
- Inputs decrypt, cbc_en, iv and num_blocks may change during a run without any effect on it.

Test Plan:
- ECB encrypt, key 133457799BBCDFF1, N=1, input RAM [0]=89ABCDEF, [1]=01234567 -> output RAM [0]=0F0AB405, [1]=85E81354; done in cycle 23; exactly 2 writes.
- ECB decrypt, N=1, input RAM [0]=0F0AB405, [1]=85E81354 -> output RAM [0]=89ABCDEF, [1]=01234567.
- CBC encrypt, N=3, iv=0123456789ABCDEF, plaintext all zero -> block 0 ciphertext = 85E813540F0AB405; blocks 1-2 match the bench model. CBC decrypt of that output with the same iv -> all-zero plaintext restored.
- num_blocks=0 with random data -> 256 blocks processed; done in cycle 5633; output RAM matches the model; ramI_addr and ramO_addr both end at 0.
- abort asserted with des_round_sel==7 in block 2 -> IDLE next cycle; no done pulse; output RAM words 2..3 not written; a new start afterwards runs correctly.
- start pulsed in cycle 10 of a run -> ignored, done count unchanged. reset_n low in the middle of ROUND -> all outputs are 0 at the next edge.
